lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit in the memory stage, directly downstream of the execute stage.
- Consumes the execute stage's ALU result as the effective address, `rs2_data` as store data, and the `rmem`/`wmem` controls.
- Runs one memory transaction at a time on a simple req/gnt/rvalid data bus.
- Returns sign- or zero-extended load data for writeback, and stalls the pipeline while a transaction is outstanding.

Parameters:
- `ADDR_W`, 32, width of the effective address and of `bus_addr`.
- `DATA_W`, 32, data width; must equal the `RegBus` width (32).

Ports:
- `clk`  in  1  the only clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a memory instruction (`rmem|wmem`) this cycle.
- `rmem`  in  1  load.
- `wmem`  in  1  store.
- `mem_type`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  effective address (execute result).
- `wdata`  in  32  store data (`rs2_data`).
- `rd_data`  out  32  extended load result, valid while `done`=1.
- `done`  out  1  one-cycle pulse: transaction complete.
- `stall`  out  1  holds upstream stages.
- `misalign`  out  1  one-cycle pulse: misaligned access, no bus traffic.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  response (read data or write ack).
- `bus_rdata`  in  32  read data.

Behaviour:
- **States:** IDLE, REQ, RESP, DONE, ERR. All outputs are registered except `stall`.
- **Reset:** state = IDLE. `bus_req`, `bus_we`, `done`, `misalign` = 0. `bus_addr`, `bus_be`, `bus_wdata`, `rd_data` = 0.
- **IDLE:**
  - If `req_valid`=1, capture `rmem`, `wmem`, `mem_type`, `addr`, `wdata`.
  - Aligned access → REQ with `bus_req`=1.
  - Misaligned access (H/HU with `addr[0]`, W with `addr[1:0]`≠0) → ERR, no bus request.
  - If `rmem` and `wmem` are both 1, the access is a load.
  - Any funct3 not in {000, 001, 010, 100, 101} is treated as W.
- **REQ:** hold `bus_req`/`addr`/`be`/`wdata` stable until `bus_gnt`=1. On grant, `bus_req` drops next cycle and state → RESP. No timeout.
- **RESP:** wait for `bus_rvalid`. Before RESP is entered, `bus_rvalid` is ignored. On `rvalid`, register the extracted load data into `rd_data` (stores leave it unchanged) → DONE.
- **DONE:** `done`=1 for exactly one cycle, then → IDLE unconditionally. `req_valid` in DONE belongs to the completed instruction and is ignored.
- **ERR:** `misalign`=1 for one cycle → IDLE. `done` stays 0.
- **stall:**
  - 1 in IDLE when `req_valid` and the access is aligned.
  - 1 in REQ and RESP.
  - 0 in DONE, ERR, and otherwise.
- **Byte enables / store data:**
  - B: `be` = `4'b0001 << addr[1:0]`, `wdata` = byte replicated ×4.
  - H: `be` = `addr[1] ? 1100 : 0011`, `wdata` = half replicated ×2.
  - W: `be` = 1111, `wdata` as given.
  - Loads drive the same `be` with `bus_we`=0.
- **Load extract:**
  - `lane = bus_rdata >> (8*addr[1:0])`.
  - B/H sign-extend `lane[7:0]` / `lane[15:0]`.
  - BU/HU zero-extend.
  - W passes through.
- **Minimum latency:** request in cycle 0, `gnt` in cycle 1, `rvalid` in cycle 2, `done` in cycle 3. Each wait cycle on `gnt` or `rvalid` adds one.
- **Reset mid-transaction:** state → IDLE and `bus_req` = 0 in the next cycle. A stale `rvalid` arriving in IDLE is ignored.

Decomposition:
- **Shared defines (`defines.v`):** `RegBus`, plus the mem_type codes `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`.
- **Local localparams:** FSM state encodings.
- **Sub-module `lsu_align`:** purely combinational. Computes `be`, replicated `wdata`, the misalign flag, and load extraction/extension. The FSM stays in `lsu`.

Test Plan:
1. LW `addr`=0x100, `gnt` in cycle 1, `rvalid` in cycle 2 with `rdata`=0xDEADBEEF → `bus_addr`=0x100, `be`=1111; `done` in cycle 3 with `rd_data`=0xDEADBEEF; `stall` 1 in cycles 0–2, 0 in cycle 3.
2. LB `addr`=0x103, `rdata`=0x80FF1234 → `be`=1000, `rd_data`=0xFFFFFF80. LBU at the same address → 0x00000080.
3. SH `addr`=0x202, `wdata`=0x0000ABCD, `gnt` delayed 3 cycles → `bus_we`=1, `be`=1100, `bus_wdata`=0xABCDABCD held stable until `gnt`; `done` after `rvalid`; `rd_data` unchanged.
4. LW `addr`=0x101 → no `bus_req`; `misalign` pulses one cycle; `done`=0; `stall` never asserted.
5. Assert `rst` in RESP, then `rvalid` in the cycle after reset → IDLE; no `done`; `rd_data`=0; the next LW completes normally.
6. `req_valid` held high through DONE for one instruction → exactly one bus transaction and one `done` pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: register width,
// funct3 access-size codes and the request context held across a transaction.
package lsu_pkg;

  localparam int REG_BUS = 32;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef struct packed {
    logic       is_store;
    logic [2:0] mtype;
    logic [1:0] off;
  } lsu_ctl_t;

  // Reserved funct3 encodings fall back to a full-word access.
  function automatic logic [2:0] norm_type(input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: return f3;
      default:                             return LSU_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory-side bus of the load/store unit: single outstanding req/gnt with a
// separate rvalid response carrying read data or the write acknowledge.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = REG_BUS
);

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, alignment
// check and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]         mem_type,
  input  logic [1:0]         off,
  input  logic [REG_BUS-1:0] wdata,
  input  logic [REG_BUS-1:0] rdata,
  output logic [3:0]         be,
  output logic [REG_BUS-1:0] wdata_rep,
  output logic               misalign,
  output logic [REG_BUS-1:0] rd_ext
);

  logic [REG_BUS-1:0] lane;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (mem_type)
      LSU_B, LSU_BU: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      LSU_H, LSU_HU: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = off[0];
      end
      default: begin
        misalign  = (off != 2'b00);
      end
    endcase
  end

  // Addressed byte/half is shifted down to bit 0 before extension.
  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    case (mem_type)
      LSU_B:   rd_ext = {{24{lane[7]}}, lane[7:0]};
      LSU_BU:  rd_ext = {24'd0, lane[7:0]};
      LSU_H:   rd_ext = {{16{lane[15]}}, lane[15:0]};
      LSU_HU:  rd_ext = {16'd0, lane[15:0]};
      default: rd_ext = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: one bus transaction at a time, pipeline stall
// while outstanding, extended load data returned with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for a memory instruction from execute
//   REQ   | bus_req held with stable address/enables/data until granted
//   RESP  | granted, waiting for rvalid (read data or write ack)
//   DONE  | done pulse, rd_data valid for writeback
//   ERR   | misaligned access reported, no bus traffic issued
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = REG_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              rmem,
  input  logic              wmem,
  input  logic [2:0]        mem_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              stall,
  output logic              misalign,
  lsu_if.master             bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RESP = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  lsu_ctl_t    ctl_q;

  logic [2:0]        sel_type;
  logic [1:0]        sel_off;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rd;
  logic              al_misalign;
  logic              capture;
  logic              load_rsp;
  logic              is_store_in;

  // In IDLE the lane logic looks at the live request; afterwards it works on
  // the captured context so extraction matches the issued access.
  assign sel_type    = (state == ST_IDLE) ? norm_type(mem_type) : ctl_q.mtype;
  assign sel_off     = (state == ST_IDLE) ? addr[1:0] : ctl_q.off;
  assign is_store_in = wmem & ~rmem;

  lsu_align u_align (
    .mem_type  (sel_type),
    .off       (sel_off),
    .wdata     (wdata),
    .rdata     (bus.bus_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .misalign  (al_misalign),
    .rd_ext    (al_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ctl_q         <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      rd_data       <= '0;
      done          <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.bus_req <= (state_nxt == ST_REQ);
      done        <= (state_nxt == ST_DONE);
      misalign    <= (state_nxt == ST_ERR);
      if (capture) begin
        ctl_q.is_store <= is_store_in;
        ctl_q.mtype    <= norm_type(mem_type);
        ctl_q.off      <= addr[1:0];
        bus.bus_we     <= is_store_in;
        bus.bus_addr   <= {addr[ADDR_W-1:2], 2'b00};
        bus.bus_be     <= al_be;
        bus.bus_wdata  <= al_wdata;
      end
      if (load_rsp) begin
        rd_data <= al_rd;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = al_misalign ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.bus_gnt) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.bus_rvalid) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    capture  = 1'b0;
    load_rsp = 1'b0;
    case (state)
      ST_IDLE: begin
        stall   = req_valid & ~al_misalign;
        capture = req_valid & ~al_misalign;
      end
      ST_REQ: begin
        stall = 1'b1;
      end
      ST_RESP: begin
        stall    = 1'b1;
        load_rsp = bus.bus_rvalid & ~ctl_q.is_store;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, reset/hold sequences and
// randomized accesses against a byte-array memory reference.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        rmem;
  logic        wmem;
  logic [2:0]  mem_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        done;
  logic        stall;
  logic        misalign;

  int n_checks = 0;
  int n_err    = 0;
  int grant_cnt = 0;
  int done_cnt  = 0;

  logic [31:0] last_rd;
  logic [7:0]  ref_mem [256];
  logic [7:0]  bus_mem [256];

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  mt;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          gd;
    int          rv;
    logic        hold;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  lsu_if bif ();

  lsu dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .rmem      (rmem),
    .wmem      (wmem),
    .mem_type  (mem_type),
    .addr      (addr),
    .wdata     (wdata),
    .rd_data   (rd_data),
    .done      (done),
    .stall     (stall),
    .misalign  (misalign),
    .bus       (bif)
  );

  always @(negedge clk) begin
    if (bif.bus_req && bif.bus_gnt) grant_cnt <= grant_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width, signedness, enables, replication, load value.
  function automatic int width_of(input logic [2:0] mt);
    if (mt == 3'd0 || mt == 3'd4) return 1;
    if (mt == 3'd1 || mt == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] mt, input logic [31:0] a);
    int m;
    m = (1 << width_of(mt)) - 1;
    return 4'(m << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] mt, input logic [31:0] wd);
    logic [31:0] r;
    int w;
    w = width_of(mt);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % w) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] mt, input logic [31:0] a);
    logic [31:0] v;
    logic [7:0]  idx;
    int w;
    w = width_of(mt);
    v = '0;
    for (int i = 0; i < w; i++) begin
      idx = a[7:0] + 8'(i);
      v[8*i +: 8] = ref_mem[idx];
    end
    if ((mt == 3'd0 || mt == 3'd1) && v[8*w-1]) begin
      for (int j = 8*w; j < 32; j++) v[j] = 1'b1;
    end
    return v;
  endfunction

  task automatic run_txn(input string tag, input logic ld, input logic st, input logic [2:0] mt,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int gd, input int rv, input logic hold,
                         input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_rd,
                         input logic e_mis, output logic [3:0] got_be, output logic [31:0] got_wd);
    logic [31:0] e_addr;
    logic        e_we;
    e_addr = {a[31:2], 2'b00};
    e_we   = st & ~ld;
    got_be = '0;
    got_wd = '0;
    req_valid = 1'b1; rmem = ld; wmem = st; mem_type = mt; addr = a; wdata = wd;
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'($urandom_range(0, 1)); bif.bus_rdata = $urandom;
    @(negedge clk);
    check_b({tag, "_stall_c0"}, stall, !e_mis);
    check_b({tag, "_req_c0"}, bif.bus_req, 1'b0);
    step();
    bif.bus_rvalid = 1'b0;
    if (!hold || e_mis) begin
      req_valid = 1'b0; addr = $urandom; wdata = $urandom; mem_type = 3'($urandom_range(0, 7));
    end
    if (e_mis) begin
      @(negedge clk);
      check_b({tag, "_mis_pulse"}, misalign, 1'b1);
      check_b({tag, "_mis_done"}, done, 1'b0);
      check_b({tag, "_mis_req"}, bif.bus_req, 1'b0);
      check_b({tag, "_mis_stall"}, stall, 1'b0);
      check({tag, "_mis_rd"}, rd_data, last_rd);
      step();
      @(negedge clk);
      check_b({tag, "_mis_end"}, misalign, 1'b0);
      check_b({tag, "_mis_req2"}, bif.bus_req, 1'b0);
      step();
      return;
    end
    for (int k = 0; k <= gd; k++) begin
      bif.bus_gnt    = (k == gd);
      bif.bus_rvalid = 1'($urandom_range(0, 1));
      bif.bus_rdata  = $urandom;
      @(negedge clk);
      check_b({tag, "_req"}, bif.bus_req, 1'b1);
      check_b({tag, "_we"}, bif.bus_we, e_we);
      check({tag, "_addr"}, bif.bus_addr, e_addr);
      check({tag, "_be"}, 32'(bif.bus_be), 32'(e_be));
      if (e_we) check({tag, "_wdata"}, bif.bus_wdata, e_wd);
      check_b({tag, "_stall_req"}, stall, 1'b1);
      check_b({tag, "_done_req"}, done, 1'b0);
      if (k == gd) begin
        got_be = bif.bus_be;
        got_wd = bif.bus_wdata;
      end
      step();
    end
    bif.bus_gnt = 1'b0;
    for (int k = 0; k <= rv; k++) begin
      bif.bus_rvalid = (k == rv);
      bif.bus_rdata  = (k == rv) ? rdat : $urandom;
      @(negedge clk);
      check_b({tag, "_req_resp"}, bif.bus_req, 1'b0);
      check_b({tag, "_stall_resp"}, stall, 1'b1);
      check_b({tag, "_done_resp"}, done, 1'b0);
      step();
    end
    bif.bus_rvalid = 1'b0;
    @(negedge clk);
    check_b({tag, "_done"}, done, 1'b1);
    check_b({tag, "_stall_done"}, stall, 1'b0);
    check({tag, "_rd_data"}, rd_data, e_rd);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check_b({tag, "_done_end"}, done, 1'b0);
    check_b({tag, "_req_end"}, bif.bus_req, 1'b0);
    check_b({tag, "_stall_end"}, stall, 1'b0);
    step();
  endtask

  initial begin
    logic [3:0]  gbe;
    logic [31:0] gwd;
    logic [31:0] erd;
    int          exp_grants;
    int          g0;
    int          d0;

    rst = 1'b1; req_valid = 1'b0; rmem = 1'b0; wmem = 1'b0; mem_type = 3'd0;
    addr = '0; wdata = '0;
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      bus_mem[i] = ref_mem[i];
    end
    step();
    @(negedge clk);
    check_b("rst_req", bif.bus_req, 1'b0);
    check_b("rst_we", bif.bus_we, 1'b0);
    check("rst_addr", bif.bus_addr, 32'h0);
    check("rst_be", 32'(bif.bus_be), 32'h0);
    check("rst_wdata", bif.bus_wdata, 32'h0);
    check("rst_rd", rd_data, 32'h0);
    check_b("rst_done", done, 1'b0);
    check_b("rst_mis", misalign, 1'b0);
    check_b("rst_stall", stall, 1'b0);
    step();
    rst = 1'b0;
    last_rd = '0;

    vecs.push_back('{"lw_basic",   1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,          32'hDEADBEEF, 0, 0, 1'b0, 4'b1111, 32'h0,          32'hDEADBEEF, 1'b0});
    vecs.push_back('{"lb_sign",    1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,          32'h80FF1234, 0, 0, 1'b0, 4'b1000, 32'h0,          32'hFFFFFF80, 1'b0});
    vecs.push_back('{"lbu_zero",   1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,          32'h80FF1234, 0, 0, 1'b0, 4'b1000, 32'h0,          32'h00000080, 1'b0});
    vecs.push_back('{"sh_gntwait", 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000ABCD,   32'h0,        3, 1, 1'b0, 4'b1100, 32'hABCDABCD,   32'h0,        1'b0});
    vecs.push_back('{"lw_mis",     1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,          32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,          32'h0,        1'b1});
    vecs.push_back('{"lh_sign",    1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,          32'h80017FFF, 1, 0, 1'b0, 4'b1100, 32'h0,          32'hFFFF8001, 1'b0});
    vecs.push_back('{"lhu_zero",   1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,          32'h8001F00D, 0, 2, 1'b0, 4'b0011, 32'h0,          32'h0000F00D, 1'b0});
    vecs.push_back('{"sb_lane1",   1'b0, 1'b1, 3'b000, 32'h0000_03F1, 32'h000000A5,   32'h0,        1, 2, 1'b0, 4'b0010, 32'hA5A5A5A5,   32'h0,        1'b0});
    vecs.push_back('{"sw_pass",    1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h12345678,   32'h0,        0, 0, 1'b0, 4'b1111, 32'h12345678,   32'h0,        1'b0});
    vecs.push_back('{"f3_011_mis", 1'b1, 1'b0, 3'b011, 32'h0000_0402, 32'h0,          32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,          32'h0,        1'b1});
    vecs.push_back('{"f3_110_w",   1'b1, 1'b0, 3'b110, 32'h0000_0404, 32'h0,          32'hCAFEBABE, 2, 1, 1'b0, 4'b1111, 32'h0,          32'hCAFEBABE, 1'b0});
    vecs.push_back('{"ld_and_st",  1'b1, 1'b1, 3'b010, 32'h0000_0408, 32'hFFFFFFFF,   32'h0BADF00D, 0, 0, 1'b0, 4'b1111, 32'h0,          32'h0BADF00D, 1'b0});
    vecs.push_back('{"lh_mis3",    1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,          32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,          32'h0,        1'b1});
    vecs.push_back('{"sh_mis1",    1'b0, 1'b1, 3'b001, 32'h0000_0201, 32'h0000BEEF,   32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,          32'h0,        1'b1});
    vecs.push_back('{"lb_hold",    1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,          32'h00007F00, 2, 0, 1'b1, 4'b0010, 32'h0,          32'h0000007F, 1'b0});
    vecs.push_back('{"lbu_lane2",  1'b1, 1'b0, 3'b100, 32'h0000_1002, 32'h0,          32'h00C30000, 0, 1, 1'b0, 4'b0100, 32'h0,          32'h000000C3, 1'b0});
    vecs.push_back('{"sh_lane0",   1'b0, 1'b1, 3'b001, 32'h7FFF_FFFC, 32'hFFFF1357,   32'h0,        1, 0, 1'b1, 4'b0011, 32'h13571357,   32'h0,        1'b0});

    exp_grants = 0;
    g0 = grant_cnt;
    d0 = done_cnt;
    foreach (vecs[i]) begin
      erd = vecs[i].ld ? vecs[i].e_rd : last_rd;
      run_txn(vecs[i].name, vecs[i].ld, vecs[i].st, vecs[i].mt, vecs[i].a, vecs[i].wd, vecs[i].rdat,
              vecs[i].gd, vecs[i].rv, vecs[i].hold, vecs[i].e_be, vecs[i].e_wd, erd, vecs[i].e_mis,
              gbe, gwd);
      if (!vecs[i].e_mis) begin
        exp_grants++;
        last_rd = erd;
      end
    end
    check("table_grants", 32'(grant_cnt - g0), 32'(exp_grants));
    check("table_dones", 32'(done_cnt - d0), 32'(exp_grants));

    // Reset while waiting for the response, with a stale rvalid right after.
    req_valid = 1'b1; rmem = 1'b1; wmem = 1'b0; mem_type = 3'b010; addr = 32'h100;
    step();
    req_valid = 1'b0;
    bif.bus_gnt = 1'b1;
    step();
    bif.bus_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_b("rstmid_stall_resp", stall, 1'b1);
    step();
    rst = 1'b0;
    bif.bus_rvalid = 1'b1;
    bif.bus_rdata  = 32'h12345678;
    @(negedge clk);
    check_b("rstmid_req", bif.bus_req, 1'b0);
    check_b("rstmid_done", done, 1'b0);
    check("rstmid_rd", rd_data, 32'h0);
    check_b("rstmid_stall", stall, 1'b0);
    step();
    bif.bus_rvalid = 1'b0;
    @(negedge clk);
    check_b("rstmid_stale_done", done, 1'b0);
    check("rstmid_stale_rd", rd_data, 32'h0);
    step();
    last_rd = '0;
    run_txn("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hA5A50001, 0, 0, 1'b0,
            4'b1111, 32'h0, 32'hA5A50001, 1'b0, gbe, gwd);
    last_rd = 32'hA5A50001;

    // req_valid held through DONE must yield a single transaction.
    g0 = grant_cnt;
    d0 = done_cnt;
    run_txn("hold_once", 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h55AA55AA, 0, 0, 1'b1,
            4'b1111, 32'h0, 32'h55AA55AA, 1'b0, gbe, gwd);
    last_rd = 32'h55AA55AA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_b("hold_idle_req", bif.bus_req, 1'b0);
      step();
    end
    check("hold_grants", 32'(grant_cnt - g0), 32'd1);
    check("hold_dones", 32'(done_cnt - d0), 32'd1);

    for (int n = 0; n < 150; n++) begin
      int          op;
      int          w;
      logic        ld;
      logic        st;
      logic        hold;
      logic        mis;
      logic [2:0]  mt;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rdat;
      logic [7:0]  wa;
      logic [7:0]  idx;
      op   = $urandom_range(0, 9);
      ld   = (op < 5) || (op == 9);
      st   = (op >= 5);
      mt   = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      a    = $urandom;
      w    = width_of(mt);
      if ($urandom_range(0, 2) != 0) a[1:0] = a[1:0] & 2'(~(w - 1));
      mis  = (int'(a[1:0]) % w) != 0;
      wd   = $urandom;
      hold = 1'($urandom_range(0, 1));
      wa   = a[7:0] & 8'hFC;
      rdat = {bus_mem[wa + 8'd3], bus_mem[wa + 8'd2], bus_mem[wa + 8'd1], bus_mem[wa]};
      erd  = ld ? m_load(mt, a) : last_rd;
      run_txn("rand", ld, st, mt, a, wd, rdat, $urandom_range(0, 3), $urandom_range(0, 3), hold,
              m_be(mt, a), m_wd(mt, wd), erd, mis, gbe, gwd);
      if (!mis) begin
        if (ld) begin
          last_rd = erd;
        end else begin
          for (int i = 0; i < w; i++) begin
            idx = a[7:0] + 8'(i);
            ref_mem[idx] = wd[8*i +: 8];
          end
          for (int j = 0; j < 4; j++) begin
            if (gbe[j]) bus_mem[wa + 8'(j)] = gwd[8*j +: 8];
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
